// File: rtl/wb_arb_pkg.sv
// rtl/wb_arb_pkg.sv - shared types and constants for the two-master wishbone arbiter
package wb_arb_pkg;

  // Arbiter ownership states; encoding is fixed so debug views stay stable.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OWN_M0 = 2'd1,
    OWN_M1 = 2'd2
  } arb_state_t;

  // Index of one of the two masters (0 = instruction fetch, 1 = load/store).
  typedef logic mstr_idx_t;

  // Width of the per-tenure acknowledge counter.
  localparam int BURST_CNT_W = 8;

  // Map a master index onto the state that represents its ownership.
  function automatic arb_state_t own_state(input mstr_idx_t idx);
    return idx ? OWN_M1 : OWN_M0;
  endfunction

endpackage

// File: rtl/wb_arb_rr_pick.sv
// rtl/wb_arb_rr_pick.sv - combinational two-way round-robin picker
module wb_arb_rr_pick
  import wb_arb_pkg::*;
(
  input  logic [1:0] req,
  input  mstr_idx_t  last_grant,
  output logic       valid,
  output mstr_idx_t  grant_idx
);

  // On a tie the master that did not win last time gets the bus; otherwise the lone requester.
  always_comb begin
    valid     = |req;
    grant_idx = 1'b0;
    if (req == 2'b11) begin
      grant_idx = ~last_grant;
    end else if (req[1]) begin
      grant_idx = 1'b1;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - two-master one-slave wishbone arbiter with round-robin and burst quota
module wb_arbiter
  import wb_arb_pkg::*;
#(
  parameter int MAX_BURST = 8
) (
  input  logic        clk,
  input  logic        nrst,

  // master 0: instruction fetch
  input  logic        m0_wb_cyc,
  input  logic        m0_wb_stb,
  input  logic        m0_wb_we,
  input  logic [31:0] m0_wb_addr,
  input  logic [1:0]  m0_wb_width,
  input  logic [31:0] m0_wb_data_write,
  output logic [31:0] m0_wb_data_read,
  output logic        m0_wb_ack,

  // master 1: load/store
  input  logic        m1_wb_cyc,
  input  logic        m1_wb_stb,
  input  logic        m1_wb_we,
  input  logic [31:0] m1_wb_addr,
  input  logic [1:0]  m1_wb_width,
  input  logic [31:0] m1_wb_data_write,
  output logic [31:0] m1_wb_data_read,
  output logic        m1_wb_ack,

  // shared slave
  output logic        s_wb_cyc,
  output logic        s_wb_stb,
  output logic        s_wb_we,
  output logic [31:0] s_wb_addr,
  output logic [1:0]  s_wb_width,
  output logic [31:0] s_wb_data_write,
  input  logic [31:0] s_wb_data_read,
  input  logic        s_wb_ack
);

  // Last counter value before the quota trips (counter holds acks already completed).
  localparam logic [BURST_CNT_W-1:0] BURST_LAST = BURST_CNT_W'(MAX_BURST - 1);

  arb_state_t               state, state_nxt;
  mstr_idx_t                last_grant, last_grant_nxt;
  logic [BURST_CNT_W-1:0]   burst_cnt, burst_cnt_nxt;

  logic [1:0]               req;
  logic                     owned;
  mstr_idx_t                owner;
  logic                     owner_cyc;
  logic                     other_req;
  logic                     quota_hit;
  logic                     rearb;
  logic                     pick_valid;
  mstr_idx_t                pick_idx;

  assign req[0] = m0_wb_cyc & m0_wb_stb;
  assign req[1] = m1_wb_cyc & m1_wb_stb;

  // Decode the registered owner and the conditions that end its tenure.
  always_comb begin
    owned     = (state == OWN_M0) || (state == OWN_M1);
    owner     = (state == OWN_M1);
    owner_cyc = owner ? m1_wb_cyc : m0_wb_cyc;
    other_req = owner ? req[0] : req[1];
    // The quota only bites when someone else is waiting; an uncontested owner keeps streaming.
    quota_hit = owned && s_wb_ack && (burst_cnt == BURST_LAST) && other_req;
    // Illegal encodings fall into re-arbitration so the FSM recovers on its own.
    rearb     = !owned || !owner_cyc || quota_hit;
  end

  wb_arb_rr_pick u_pick (
    .req        (req),
    .last_grant (last_grant),
    .valid      (pick_valid),
    .grant_idx  (pick_idx)
  );

  // State, round-robin pointer and burst counter registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      burst_cnt  <= '0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      burst_cnt  <= burst_cnt_nxt;
    end
  end

  // Next ownership: re-arbitrate on release, otherwise count the owner's acks.
  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    burst_cnt_nxt  = burst_cnt;
    if (rearb) begin
      if (pick_valid) begin
        state_nxt      = own_state(pick_idx);
        last_grant_nxt = pick_idx;
        burst_cnt_nxt  = '0;
      end else begin
        state_nxt      = IDLE;
      end
    end else if (s_wb_ack && (burst_cnt != BURST_LAST)) begin
      burst_cnt_nxt = burst_cnt + 1'b1;
    end
  end

  // Route the registered owner's fields to the slave and the slave response back to the owner only.
  always_comb begin
    s_wb_cyc        = 1'b0;
    s_wb_stb        = 1'b0;
    s_wb_we         = 1'b0;
    s_wb_addr       = '0;
    s_wb_width      = '0;
    s_wb_data_write = '0;
    m0_wb_ack       = 1'b0;
    m0_wb_data_read = '0;
    m1_wb_ack       = 1'b0;
    m1_wb_data_read = '0;
    case (state)
      OWN_M0: begin
        s_wb_cyc        = m0_wb_cyc;
        s_wb_stb        = m0_wb_stb;
        s_wb_we         = m0_wb_we;
        s_wb_addr       = m0_wb_addr;
        s_wb_width      = m0_wb_width;
        s_wb_data_write = m0_wb_data_write;
        m0_wb_ack       = s_wb_ack;
        m0_wb_data_read = s_wb_data_read;
      end
      OWN_M1: begin
        s_wb_cyc        = m1_wb_cyc;
        s_wb_stb        = m1_wb_stb;
        s_wb_we         = m1_wb_we;
        s_wb_addr       = m1_wb_addr;
        s_wb_width      = m1_wb_width;
        s_wb_data_write = m1_wb_data_write;
        m1_wb_ack       = s_wb_ack;
        m1_wb_data_read = s_wb_data_read;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - scoreboard bench for wb_arbiter with a transaction-level reference model
module tb_wb_arbiter;
  import wb_arb_pkg::*;

  localparam int MB = 4;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;

  logic        m0_wb_cyc, m0_wb_stb, m0_wb_we, m0_wb_ack;
  logic [31:0] m0_wb_addr, m0_wb_data_write, m0_wb_data_read;
  logic [1:0]  m0_wb_width;
  logic        m1_wb_cyc, m1_wb_stb, m1_wb_we, m1_wb_ack;
  logic [31:0] m1_wb_addr, m1_wb_data_write, m1_wb_data_read;
  logic [1:0]  m1_wb_width;
  logic        s_wb_cyc, s_wb_stb, s_wb_we, s_wb_ack;
  logic [31:0] s_wb_addr, s_wb_data_write, s_wb_data_read;
  logic [1:0]  s_wb_width;

  // master-side stimulus state
  logic        cyc [2];
  logic        stb [2];
  logic        we [2];
  logic [31:0] addr [2];
  logic [31:0] wd [2];
  logic [1:0]  wid [2];
  int          budget [2];
  int          done [2];
  logic        acked [2];
  logic        rnd_mode = 1'b0;

  // reference model state: owner (-1 idle), last winner, acks in current tenure
  int          mo = -1;
  int          mlast = 1;
  int          ten = 0;

  logic [31:0] q0 [$];
  logic [31:0] q1 [$];
  int          ack_cyc0 [$];
  int          ack_cyc1 [$];
  int          cyc_n = 0;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
  endfunction

  // combinational memory slave: acks every strobe in the same cycle
  assign s_wb_ack       = s_wb_cyc & s_wb_stb;
  assign s_wb_data_read = rom(s_wb_addr);

  assign m0_wb_cyc = cyc[0];  assign m0_wb_stb = stb[0];  assign m0_wb_we = we[0];
  assign m0_wb_addr = addr[0]; assign m0_wb_width = wid[0]; assign m0_wb_data_write = wd[0];
  assign m1_wb_cyc = cyc[1];  assign m1_wb_stb = stb[1];  assign m1_wb_we = we[1];
  assign m1_wb_addr = addr[1]; assign m1_wb_width = wid[1]; assign m1_wb_data_write = wd[1];

  wb_arbiter #(.MAX_BURST(MB)) dut (
    .clk(clk), .nrst(nrst),
    .m0_wb_cyc(m0_wb_cyc), .m0_wb_stb(m0_wb_stb), .m0_wb_we(m0_wb_we),
    .m0_wb_addr(m0_wb_addr), .m0_wb_width(m0_wb_width), .m0_wb_data_write(m0_wb_data_write),
    .m0_wb_data_read(m0_wb_data_read), .m0_wb_ack(m0_wb_ack),
    .m1_wb_cyc(m1_wb_cyc), .m1_wb_stb(m1_wb_stb), .m1_wb_we(m1_wb_we),
    .m1_wb_addr(m1_wb_addr), .m1_wb_width(m1_wb_width), .m1_wb_data_write(m1_wb_data_write),
    .m1_wb_data_read(m1_wb_data_read), .m1_wb_ack(m1_wb_ack),
    .s_wb_cyc(s_wb_cyc), .s_wb_stb(s_wb_stb), .s_wb_we(s_wb_we),
    .s_wb_addr(s_wb_addr), .s_wb_width(s_wb_width), .s_wb_data_write(s_wb_data_write),
    .s_wb_data_read(s_wb_data_read), .s_wb_ack(s_wb_ack)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // round robin in words: on a tie, whoever did not win last; else the lone requester
  function automatic int choose(input logic r0, input logic r1);
    if (r0 && r1) return 1 - mlast;
    if (r0) return 0;
    if (r1) return 1;
    return -1;
  endfunction

  // one bus cycle of the reference model: check forwarded fields, queue expected acks, advance ownership
  task automatic model_cycle();
    logic r [2];
    logic sack;
    logic rel;
    int   g;
    r[0] = cyc[0] & stb[0];
    r[1] = cyc[1] & stb[1];
    chk("state", 32'(dut.state), (mo < 0) ? 32'd0 : 32'(mo + 1));
    if (mo < 0) begin
      chk("idle_s_cyc", {31'b0, s_wb_cyc}, 32'd0);
      chk("idle_s_stb", {31'b0, s_wb_stb}, 32'd0);
      chk("idle_s_addr", s_wb_addr, 32'd0);
      chk("idle_s_dw", s_wb_data_write, 32'd0);
      chk("idle_s_we_w", {29'b0, s_wb_we, s_wb_width}, 32'd0);
      sack = 1'b0;
    end else begin
      chk("s_cyc", {31'b0, s_wb_cyc}, {31'b0, cyc[mo]});
      chk("s_stb", {31'b0, s_wb_stb}, {31'b0, stb[mo]});
      chk("s_addr", s_wb_addr, addr[mo]);
      chk("s_dw", s_wb_data_write, wd[mo]);
      chk("s_we_w", {29'b0, s_wb_we, s_wb_width}, {29'b0, we[mo], wid[mo]});
      sack = cyc[mo] & stb[mo];
    end
    if (mo != 0) chk("m0_nonowner", {m0_wb_data_read[31:1], m0_wb_data_read[0] | m0_wb_ack}, 32'd0);
    if (mo != 1) chk("m1_nonowner", {m1_wb_data_read[31:1], m1_wb_data_read[0] | m1_wb_ack}, 32'd0);
    if (sack) begin
      if (mo == 0) q0.push_back(rom(addr[0]));
      else q1.push_back(rom(addr[1]));
      acked[mo] = 1'b1;
    end
    rel = (mo < 0) || !cyc[mo] || (sack && (ten + 1 >= MB) && r[1 - mo]);
    if (rel) begin
      g = choose(r[0], r[1]);
      mo = g;
      if (g >= 0) begin
        mlast = g;
        ten = 0;
      end
    end else if (sack) begin
      ten++;
    end
  endtask

  // one clock: masters react to last cycle's acks, then the model checks this cycle
  task automatic step();
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      logic just;
      just = acked[i];
      if (acked[i]) begin
        done[i]++;
        addr[i] = addr[i] + 32'd4;
        wd[i]   = $urandom;
        we[i]   = 1'($urandom);
        wid[i]  = 2'($urandom);
        acked[i] = 1'b0;
      end
      if (rnd_mode) begin
        if (done[i] < budget[i] && just && $urandom_range(0, 5) == 0) budget[i] = done[i];
        if (done[i] >= budget[i] && $urandom_range(0, 2) == 0) begin
          budget[i] = done[i] + int'($urandom_range(1, 9));
          addr[i]   = $urandom & 32'hFFFF_FFFC;
        end
      end
      cyc[i] = (done[i] < budget[i]);
      stb[i] = cyc[i] && (!rnd_mode || $urandom_range(0, 5) != 0);
    end
    #1;
    model_cycle();
    if (m0_wb_ack) ack_cyc0.push_back(cyc_n);
    if (m1_wb_ack) ack_cyc1.push_back(cyc_n);
    cyc_n++;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  // asynchronous reset in the middle of a cycle; outputs must collapse immediately
  task automatic do_reset();
    @(negedge clk);
    nrst = 1'b0;
    #1;
    chk("rst_s_cyc", {31'b0, s_wb_cyc}, 32'd0);
    chk("rst_s_addr", s_wb_addr, 32'd0);
    chk("rst_acks", {30'b0, m0_wb_ack, m1_wb_ack}, 32'd0);
    chk("rst_m1_data", m1_wb_data_read, 32'd0);
    chk("rst_state", 32'(dut.state), 32'd0);
    for (int i = 0; i < 2; i++) begin
      cyc[i] = 1'b0; stb[i] = 1'b0; budget[i] = 0; done[i] = 0; acked[i] = 1'b0;
    end
    mo = -1; mlast = 1; ten = 0;
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    ack_cyc0.delete(); ack_cyc1.delete(); cyc_n = 0;
  endtask

  // scoreboard monitor: every owner ack must match the oldest expected response
  always @(negedge clk) begin
    #2;
    if (m0_wb_ack) begin
      if (q0.size() == 0) chk("m0_spurious_ack", {31'b0, m0_wb_ack}, 32'd0);
      else chk("m0_data", m0_wb_data_read, q0.pop_front());
    end
    if (m1_wb_ack) begin
      if (q1.size() == 0) chk("m1_spurious_ack", {31'b0, m1_wb_ack}, 32'd0);
      else chk("m1_data", m1_wb_data_read, q1.pop_front());
    end
    chk("m0_missing_ack", 32'(q0.size()), 32'd0);
    chk("m1_missing_ack", 32'(q1.size()), 32'd0);
    q0.delete();
    q1.delete();
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      cyc[i] = 1'b0; stb[i] = 1'b0; we[i] = 1'b0; addr[i] = '0; wd[i] = '0; wid[i] = '0;
      budget[i] = 0; done[i] = 0; acked[i] = 1'b0;
    end

    // first transfer after reset: grant in cycle 1 with same-cycle ack
    do_reset();
    addr[0] = 32'h10; wid[0] = 2'd2; budget[0] = 1;
    run(2);
    chk("t1_addr", s_wb_addr, 32'h10);
    chk("t1_width", {30'b0, s_wb_width}, 32'd2);
    chk("t1_m0_ack", {31'b0, m0_wb_ack}, 32'd1);
    chk("t1_m0_data", m0_wb_data_read, rom(32'h10));
    chk("t1_m1_quiet", {m1_wb_data_read[31:1], m1_wb_data_read[0] | m1_wb_ack}, 32'd0);
    run(3);

    // tie from idle: M0 first, M1 directly after M0 drops cyc
    do_reset();
    budget[0] = 2; budget[1] = 2;
    run(8);
    chk("t2_m0_first", 32'(ack_cyc0[0]), 32'd1);
    chk("t2_m1_first", 32'(ack_cyc1[0]), 32'd4);

    // quota: M0 gets exactly MB acks, stalls while M1 runs, then is regranted
    do_reset();
    budget[0] = 6; budget[1] = 3;
    run(14);
    chk("t3_m0_acks", 32'(ack_cyc0.size()), 32'd6);
    chk("t3_m0_4th", 32'(ack_cyc0[3]), 32'd4);
    chk("t3_m1_first", 32'(ack_cyc1[0]), 32'd5);
    chk("t3_m0_regrant", 32'(ack_cyc0[4]), 32'd9);

    // uncontested stream of 20 stays with M0
    do_reset();
    budget[0] = 20;
    run(23);
    chk("t4_m0_acks", 32'(ack_cyc0.size()), 32'd20);
    chk("t4_m0_last", 32'(ack_cyc0[19]), 32'd20);

    // reset while M1 owns, then a tie must go to M0
    do_reset();
    budget[1] = 10;
    run(3);
    do_reset();
    budget[0] = 1; budget[1] = 1;
    run(5);
    chk("t5_m0_first", 32'(ack_cyc0[0]), 32'd1);
    chk("t5_m1_first", 32'(ack_cyc1[0]), 32'd3);

    // M0 toggles cyc: grant, idle, regrant
    do_reset();
    budget[0] = 1;
    run(3);
    budget[0] = 2;
    run(3);
    chk("t6_acks", 32'(ack_cyc0.size()), 32'd2);
    chk("t6_first", 32'(ack_cyc0[0]), 32'd1);
    chk("t6_second", 32'(ack_cyc0[1]), 32'd4);

    // randomized contention
    do_reset();
    rnd_mode = 1'b1;
    run(3000);
    rnd_mode = 1'b0;
    budget[0] = done[0]; budget[1] = done[1];
    run(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
